// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising CPU (port 0) and loader/debug (port 1) accesses onto one memory.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is fixed priority to port 0.
module mem_arbiter #(
   parameter int W  = 8,
   parameter int AW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req,
   input  logic [1:0]      wr,
   input  logic [2*AW-1:0] addr,
   input  logic [2*W-1:0]  wdata,
   output logic [1:0]      gnt,
   output logic [1:0]      done,
   output logic [W-1:0]    rdata,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic [AW-1:0]   mem_addr,
   output logic [W-1:0]    mem_wdata,
   input  logic [W-1:0]    mem_rdata,
   output logic            busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GRANT  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          win_q, win_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [W-1:0]  wdata_q, wdata_d;
   logic [W-1:0]  rdata_q, rdata_d;
   logic          pick;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a conflict the port that did not win last time is served.
   always_comb begin
      if (req == 2'b11) pick = ~last_q;
      else              pick = ~req[0];
   end

   assign last_d = (state_q == S_IDLE && req != 2'b00) ? pick : last_q;

   always_ff @(posedge clk) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end
`else
   assign pick = ~req[0];
`endif

   always_comb begin
      // NOTE: every next-state value is defaulted first so no branch can infer a latch.
      state_d = state_q;
      win_d   = win_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_GRANT;
               win_d   = pick;
               wr_d    = wr[pick];
               addr_d  = pick ? addr[2*AW-1:AW] : addr[AW-1:0];
               wdata_d = pick ? wdata[2*W-1:W]  : wdata[W-1:0];
            end
         end
         S_GRANT:  state_d = S_ACCESS;
         S_ACCESS: state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            if (!wr_q) rdata_d = mem_rdata;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it lives inside the clocked block; non-blocking keeps all registers edge-consistent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         win_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign gnt       = (state_q == S_GRANT) ? {win_q, ~win_q} : 2'b00;
   assign done      = (state_q == S_DONE)  ? {win_q, ~win_q} : 2'b00;
   assign mem_rd    = (state_q == S_ACCESS) && !wr_q;
   assign mem_wr    = (state_q == S_ACCESS) &&  wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule
